pdata_seq: RTL and testbench

Command sequencer sitting directly upstream of the `pdata` serial multiply-accumulate datapath. It owns `pdata`'s `opcode` and `rx` inputs and samples its `tx` output. It accepts parallel commands over a valid/ready handshake (load operands and multiply, load and multiply-accumulate, read the accumulator, clear the accumulator) and turns each into the exact bit-serial opcode/rx sequence `pdata` needs. Accumulator readback is returned as a parallel word.

---
 rtl/pdata_seq_if.sv | 27 ++
 rtl/pdata_seq.sv | 140 ++++++++++++++
 tb/tb_pdata_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pdata_seq_if.sv
// Command/result bus and pdata-side serial pins of the pdata_seq command sequencer.
// The command issuer (and attached pdata) takes the master side; the sequencer takes the slave side.
interface pdata_seq_if #(
  parameter int SIZE = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [SIZE-1:0]     cmd_a;
  logic [SIZE-1:0]     cmd_b;
  logic                done;
  logic                res_valid;
  logic [4*SIZE-1:0]   res_data;
  logic [2:0]          pd_opcode;
  logic                pd_rx;
  logic                pd_tx;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, pd_tx,
    input  cmd_ready, done, res_valid, res_data, pd_opcode, pd_rx
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, pd_tx,
    output cmd_ready, done, res_valid, res_data, pd_opcode, pd_rx
  );
endinterface

// File: rtl/pdata_seq.sv
// Sequencer turning parallel MUL/MAC/READ/CLEAR commands into pdata's bit-serial opcode/rx stream.
// Define PDATA_SEQ_RESTORE_EN to loop tx back into rx during READ (non-destructive readback).
module pdata_seq #(
  parameter int SIZE = 32
) (
  input  logic        clk,
  input  logic        rst,
  pdata_seq_if.slave  bus
);
  localparam int AW = 4 * SIZE;
  localparam int CW = $clog2(AW + 1);

  localparam logic [2:0] OP_OUT_RES  = 3'd2;
  localparam logic [2:0] OP_LOAD     = 3'd3;
  localparam logic [2:0] OP_LOAD_RES = 3'd4;
  localparam logic [2:0] OP_MUL      = 3'd5;
  localparam logic [2:0] OP_MUL_ADD  = 3'd6;
  localparam logic [2:0] OP_NOP      = 3'd7;

  localparam logic [CW-1:0] LD_LAST = CW'(2 * SIZE - 1);
  localparam logic [CW-1:0] SR_LAST = CW'(AW - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_READ, S_CLEAR} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            mac_q;
  logic [AW-1:0]   sh_q, sh_d, res_q;
  logic            ready_q, done_q, rv_q;
  logic [2:0]      opc_q;
  logic            rx_q;

  // sh_q doubles as the operand serializer in LOAD and the readback deserializer in READ.
  always_comb sh_d = {sh_q[AW-2:0], bus.pd_tx};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mac_q   <= 1'b0;
      sh_q    <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      opc_q   <= OP_NOP;
      rx_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rv_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.cmd_valid) begin
          ready_q <= 1'b0;
          cnt_q   <= '0;
          mac_q   <= (bus.cmd_op == 2'd1);
          case (bus.cmd_op)
            2'd0, 2'd1: begin
              state_q <= S_LOAD;
              opc_q   <= OP_LOAD;
              rx_q    <= bus.cmd_b[SIZE-1];
              sh_q    <= {bus.cmd_b[SIZE-2:0], bus.cmd_a, {(2*SIZE+1){1'b0}}};
            end
            2'd2: begin
              state_q <= S_READ;
              opc_q   <= OP_OUT_RES;
              rx_q    <= 1'b0;
            end
            default: begin
              state_q <= S_CLEAR;
              opc_q   <= OP_LOAD_RES;
              rx_q    <= 1'b0;
            end
          endcase
        end
        S_LOAD: begin
          if (cnt_q == LD_LAST) begin
            state_q <= S_EXEC;
            cnt_q   <= '0;
            opc_q   <= mac_q ? OP_MUL_ADD : OP_MUL;
            rx_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            rx_q  <= sh_q[AW-1];
            sh_q  <= {sh_q[AW-2:0], 1'b0};
          end
        end
        S_EXEC: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
          opc_q   <= OP_NOP;
        end
        S_READ: begin
          sh_q <= sh_d;
          if (cnt_q == SR_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            rv_q    <= 1'b1;
            res_q   <= sh_d;
            opc_q   <= OP_NOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CLEAR: begin
          if (cnt_q == SR_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            opc_q   <= OP_NOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b1;
          opc_q   <= OP_NOP;
          rx_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.res_valid = rv_q;
  assign bus.res_data  = res_q;
  assign bus.pd_opcode = opc_q;
`ifdef PDATA_SEQ_RESTORE_EN
  // Same-cycle loopback rotates pdata's accumulator back into place during readback.
  assign bus.pd_rx = (state_q == S_READ) ? bus.pd_tx : rx_q;
`else
  assign bus.pd_rx = rx_q;
`endif
endmodule

// File: tb/tb_pdata_seq.sv
// Self-checking bench for pdata_seq with a behavioural pdata attached and an arithmetic accumulator model.
module tb_pdata_seq;
  localparam int S  = 8;
  localparam int AW = 4 * S;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pdata_seq_if #(.SIZE(S)) bus();
  pdata_seq #(.SIZE(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vec = 0;
  int err = 0;

  // Behavioural pdata: serial load into {data_2,data_1}, serial accumulator shift, multiply/MAC.
  logic [S-1:0]  m_d1, m_d2;
  logic [AW-1:0] m_acc;
  assign bus.pd_tx = (bus.pd_opcode == 3'd2) ? m_acc[AW-1] : 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_d1 <= '0; m_d2 <= '0; m_acc <= '0;
    end else begin
      case (bus.pd_opcode)
        3'd3: {m_d2, m_d1} <= {m_d2[S-2:0], m_d1, bus.pd_rx};
        3'd4, 3'd2: m_acc <= {m_acc[AW-2:0], bus.pd_rx};
        3'd5: m_acc <= AW'(m_d1) * AW'(m_d2);
        3'd6: m_acc <= m_acc + AW'(m_d1) * AW'(m_d2);
        default: ;
      endcase
    end
  end

  // Command-level reference model.
  logic [AW-1:0] ref_acc = '0;
  logic [AW-1:0] ref_res = '0;
  logic [2:0]    tr_op [0:AW+7];
  logic          tr_rx [0:AW+7];

  function automatic int exp_lat(input logic [1:0] op);
    return (op < 2'd2) ? 2*S+2 : 4*S+1;
  endfunction

  task automatic model(input logic [1:0] op, input logic [S-1:0] a, input logic [S-1:0] b);
    case (op)
      2'd0: ref_acc = AW'(a) * AW'(b);
      2'd1: ref_acc = ref_acc + AW'(a) * AW'(b);
      2'd2: begin
        ref_res = ref_acc;
`ifndef PDATA_SEQ_RESTORE_EN
        ref_acc = '0;
`endif
      end
      default: ref_acc = '0;
    endcase
  endtask

  // Issues one command and returns edges-to-done (accept edge = 1), or -1 if done never came.
  task automatic run_cmd(input logic [1:0] op, input logic [S-1:0] a, input logic [S-1:0] b,
                         output int lat, output logic rv, output logic [AW-1:0] rd);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.cmd_ready && w < 100) begin @(negedge clk); w++; end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    model(op, a, b);
    lat = -1; rv = 1'b0; rd = '0;
    for (int k = 1; k <= AW+8; k++) begin
      @(negedge clk);
      if (k == 1) bus.cmd_valid = 1'b0;
      tr_op[k-1] = bus.pd_opcode;
      tr_rx[k-1] = bus.pd_rx;
      if (bus.done) begin lat = k; rv = bus.res_valid; rd = bus.res_data; break; end
    end
    if (lat < 0) rd = bus.res_data;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (bus.cmd_ready !== 1'b1) begin err++; $display("FAIL rst_ready: got %b want 1", bus.cmd_ready); end
    vec++; if (bus.done !== 1'b0 || bus.res_valid !== 1'b0) begin err++; $display("FAIL rst_pulses: got done=%b rv=%b want 0", bus.done, bus.res_valid); end
    vec++; if (bus.res_data !== '0) begin err++; $display("FAIL rst_res: got %h want 0", bus.res_data); end
    vec++; if (bus.pd_opcode !== 3'd7 || bus.pd_rx !== 1'b0) begin err++; $display("FAIL rst_pd: got op=%0d rx=%b want 7/0", bus.pd_opcode, bus.pd_rx); end
    rst = 1'b0;
  endtask

  task automatic test_mul_read;
    int lat; logic rv; logic [AW-1:0] rd; logic [2*S-1:0] ld; int bad_op, bad_rx;
    logic [S-1:0] a, b;
    a = 8'd3; b = 8'd5; ld = {b, a};
    run_cmd(2'd0, a, b, lat, rv, rd);
    vec++; if (lat !== 18) begin err++; $display("FAIL mul_lat: got %0d want 18", lat); end
    bad_op = 0; bad_rx = 0;
    for (int i = 0; i < 2*S; i++) begin
      if (tr_op[i] !== 3'd3) bad_op++;
      if (tr_rx[i] !== ld[2*S-1-i]) bad_rx++;
    end
    if (tr_op[2*S] !== 3'd5) bad_op++;
    if (tr_op[2*S+1] !== 3'd7) bad_op++;
    vec++; if (bad_op != 0) begin err++; $display("FAIL mul_op_trace: got %0d bad cycles want 0", bad_op); end
    vec++; if (bad_rx != 0) begin err++; $display("FAIL mul_rx_trace: got %0d bad bits want 0", bad_rx); end
    @(negedge clk);
    vec++; if (bus.done !== 1'b0) begin err++; $display("FAIL done_pulse: got %b want 0", bus.done); end
    run_cmd(2'd2, '0, '0, lat, rv, rd);
    vec++; if (lat !== 33 || rv !== 1'b1) begin err++; $display("FAIL read_lat: got lat=%0d rv=%b want 33/1", lat, rv); end
    vec++; if (rd !== ref_res || rd !== AW'(15)) begin err++; $display("FAIL read15: got %0d want %0d", rd, ref_res); end
    @(negedge clk);
    vec++; if (bus.res_valid !== 1'b0 || bus.res_data !== ref_res) begin err++; $display("FAIL res_hold: got rv=%b data=%0d want 0/%0d", bus.res_valid, bus.res_data, ref_res); end
  endtask

  task automatic test_mac;
    int lat; logic rv; logic [AW-1:0] rd;
    run_cmd(2'd1, 8'd2, 8'd7, lat, rv, rd);
    vec++; if (lat !== 18) begin err++; $display("FAIL mac_lat: got %0d want 18", lat); end
    run_cmd(2'd2, '0, '0, lat, rv, rd);
    vec++; if (rd !== ref_res) begin err++; $display("FAIL mac_read: got %0d want %0d", rd, ref_res); end
    run_cmd(2'd3, '0, '0, lat, rv, rd);
    run_cmd(2'd1, 8'hFF, 8'hFF, lat, rv, rd);
    run_cmd(2'd2, '0, '0, lat, rv, rd);
    vec++; if (rd !== ref_res || rd !== AW'(16'hFE01)) begin err++; $display("FAIL mac_ff: got %h want %h", rd, ref_res); end
  endtask

  task automatic test_clear;
    int lat; logic rv; logic [AW-1:0] rd; int bad;
    run_cmd(2'd0, 8'd200, 8'd77, lat, rv, rd);
    run_cmd(2'd3, '0, '0, lat, rv, rd);
    vec++; if (lat !== 33 || rv !== 1'b0) begin err++; $display("FAIL clear_lat: got lat=%0d rv=%b want 33/0", lat, rv); end
    bad = 0;
    for (int i = 0; i < AW; i++) if (tr_op[i] !== 3'd4 || tr_rx[i] !== 1'b0) bad++;
    vec++; if (bad != 0) begin err++; $display("FAIL clear_trace: got %0d bad cycles want 0", bad); end
    run_cmd(2'd2, '0, '0, lat, rv, rd);
    vec++; if (rd !== '0 || lat !== 33) begin err++; $display("FAIL clear_read: got %0d lat=%0d want 0/33", rd, lat); end
  endtask

  task automatic test_double_read;
    int lat; logic rv; logic [AW-1:0] rd;
    run_cmd(2'd3, '0, '0, lat, rv, rd);
    run_cmd(2'd0, 8'd9, 8'd9, lat, rv, rd);
    run_cmd(2'd2, '0, '0, lat, rv, rd);
    vec++; if (rd !== ref_res || rd !== AW'(81)) begin err++; $display("FAIL read1: got %0d want %0d", rd, ref_res); end
    run_cmd(2'd2, '0, '0, lat, rv, rd);
    vec++; if (rd !== ref_res) begin err++; $display("FAIL read2: got %0d want %0d", rd, ref_res); end
  endtask

  task automatic test_back_to_back;
    logic [S-1:0] a, b; int bad_rdy, lat1, lat2;
    a = S'($urandom); b = S'($urandom);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_a = a; bus.cmd_b = b;
    model(2'd0, a, b);
    bad_rdy = 0; lat1 = -1; lat2 = -1;
    for (int k = 1; k <= AW+8; k++) begin
      @(negedge clk);
      if (bus.done) begin lat1 = k; break; end
      if (bus.cmd_ready !== 1'b0) bad_rdy++;
    end
    vec++; if (lat1 !== 18 || bus.cmd_ready !== 1'b1) begin err++; $display("FAIL b2b_mul: got lat=%0d rdy=%b want 18/1", lat1, bus.cmd_ready); end
    bus.cmd_op = 2'd2;
    model(2'd2, '0, '0);
    for (int k = 1; k <= AW+8; k++) begin
      @(negedge clk);
      if (k == 1) bus.cmd_valid = 1'b0;
      if (bus.done) begin lat2 = k; break; end
      if (bus.cmd_ready !== 1'b0) bad_rdy++;
    end
    vec++; if (lat2 !== 33 || bus.res_data !== ref_res) begin err++; $display("FAIL b2b_read: got lat=%0d data=%0d want 33/%0d", lat2, bus.res_data, ref_res); end
    vec++; if (bad_rdy != 0) begin err++; $display("FAIL b2b_ready: got %0d busy cycles with ready want 0", bad_rdy); end
  endtask

  task automatic test_random;
    int lat; logic rv; logic [AW-1:0] rd; logic [1:0] op;
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      run_cmd(op, S'($urandom), S'($urandom), lat, rv, rd);
      vec++;
      if (lat !== exp_lat(op) || rv !== (op == 2'd2) || rd !== ref_res) begin
        err++; $display("FAIL rand_%0d op%0d: got lat=%0d rv=%b data=%h want %0d/%b/%h",
                        n, op, lat, rv, rd, exp_lat(op), (op == 2'd2), ref_res);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic rv; logic [AW-1:0] rd;
    run_cmd(2'd0, 8'd9, 8'd9, lat, rv, rd);
    run_cmd(2'd2, '0, '0, lat, rv, rd);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_a = 8'h12; bus.cmd_b = 8'h34;
    repeat (6) @(negedge clk);
    bus.cmd_valid = 1'b0;
    vec++; if (bus.pd_opcode !== 3'd3 || bus.cmd_ready !== 1'b0) begin err++; $display("FAIL mid_load: got op=%0d rdy=%b want 3/0", bus.pd_opcode, bus.cmd_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_acc = '0; ref_res = '0;
    vec++;
    if (bus.pd_opcode !== 3'd7 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.res_data !== '0) begin
      err++; $display("FAIL mid_rst: got op=%0d rdy=%b done=%b data=%0d want 7/1/0/0",
                      bus.pd_opcode, bus.cmd_ready, bus.done, bus.res_data);
    end
    run_cmd(2'd2, '0, '0, lat, rv, rd);
    vec++; if (lat !== 33 || rd !== ref_res) begin err++; $display("FAIL post_rst_read: got lat=%0d data=%0d want 33/%0d", lat, rd, ref_res); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    test_reset();
    test_mul_read();
    test_mac();
    test_clear();
    test_double_read();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
